// File: rtl/lru_replace_ctrl.sv
// Per-set LRU victim selector: 32-bit use stamps per way and a serial min-scan, one way per cycle.
// Victim offered SET_SIZE+1 cycles after request; touches never stall; commit waits on victim_ready.
module lru_replace_ctrl #(
  parameter int SET_SIZE  = 4,
  parameter int SET_COUNT = 8,
  localparam int WAY_W    = $clog2(SET_SIZE),
  localparam int SET_W    = $clog2(SET_COUNT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             touch_valid,
  input  logic [SET_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             miss_valid,
  input  logic [SET_W-1:0] miss_set,
  output logic             miss_ready,
  output logic             victim_valid,
  output logic [WAY_W-1:0] victim_way,
  input  logic             victim_ready
);

  typedef enum logic [1:0] {IDLE, SEARCH, OFFER} state_e;

  state_e state_q, state_d;

  logic [31:0]      stamp_q [SET_COUNT][SET_SIZE];
  logic [31:0]      counter_q, counter_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [WAY_W-1:0] scan_q, scan_d;
  logic [WAY_W-1:0] best_way_q, best_way_d;
  logic [31:0]      best_stamp_q, best_stamp_d;

  logic        accept, commit, restart, last_scan;
  logic [31:0] scan_stamp, inc1, inc2, touch_val;

  assign accept     = (state_q == IDLE) && miss_valid;
  assign commit     = (state_q == OFFER) && victim_ready;
  assign restart    = (state_q == SEARCH) && touch_valid && (touch_set == set_q);
  assign last_scan  = (scan_q == WAY_W'(SET_SIZE - 1));
  assign scan_stamp = stamp_q[set_q][scan_q];

  // Counter saturates at all-ones; a commit plus a touch consumes two values.
  assign inc1      = (counter_q == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : counter_q + 32'd1;
  assign inc2      = (counter_q >= 32'hFFFF_FFFE) ? 32'hFFFF_FFFF : counter_q + 32'd2;
  assign touch_val = commit ? inc1 : counter_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_valid) state_d = SEARCH;
      SEARCH:  if (!restart && last_scan) state_d = OFFER;
      OFFER:   if (victim_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    miss_ready   = (state_q == IDLE);
    victim_valid = (state_q == OFFER);
    victim_way   = (state_q == OFFER) ? best_way_q : '0;
  end

  always_comb begin
    set_d        = set_q;
    scan_d       = scan_q;
    best_way_d   = best_way_q;
    best_stamp_d = best_stamp_q;
    if (accept) begin
      set_d        = miss_set;
      scan_d       = '0;
      best_way_d   = '0;
      best_stamp_d = '0;
    end else if (state_q == SEARCH) begin
      if (restart) begin
        scan_d       = '0;
        best_way_d   = '0;
        best_stamp_d = '0;
      end else begin
        // Strict compare keeps the lower index on ties; way 0 always seeds the candidate.
        if ((scan_q == '0) || (scan_stamp < best_stamp_q)) begin
          best_way_d   = scan_q;
          best_stamp_d = scan_stamp;
        end
        scan_d = scan_q + WAY_W'(1);
      end
    end
  end

  always_comb begin
    counter_d = counter_q;
    if (commit)           counter_d = touch_valid ? inc2 : inc1;
    else if (touch_valid) counter_d = inc1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q    <= 32'd1;
      set_q        <= '0;
      scan_q       <= '0;
      best_way_q   <= '0;
      best_stamp_q <= '0;
      for (int s = 0; s < SET_COUNT; s++)
        for (int w = 0; w < SET_SIZE; w++)
          stamp_q[s][w] <= '0;
    end else begin
      counter_q    <= counter_d;
      set_q        <= set_d;
      scan_q       <= scan_d;
      best_way_q   <= best_way_d;
      best_stamp_q <= best_stamp_d;
      if (commit)      stamp_q[set_q][best_way_q]  <= counter_q;
      // Touch is written last so it wins over a commit to the same entry.
      if (touch_valid) stamp_q[touch_set][touch_way] <= touch_val;
    end
  end

endmodule

// File: tb/tb_lru_replace_ctrl.sv
// Bench for lru_replace_ctrl: argmin-over-stamps reference model checked every cycle, plus directed literal checks.
module tb_lru_replace_ctrl;
  localparam int SET_SIZE  = 4;
  localparam int SET_COUNT = 8;
  localparam int WAY_W     = 2;
  localparam int SET_W     = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             touch_valid = 1'b0;
  logic [SET_W-1:0] touch_set = '0;
  logic [WAY_W-1:0] touch_way = '0;
  logic             miss_valid = 1'b0;
  logic [SET_W-1:0] miss_set = '0;
  logic             miss_ready;
  logic             victim_valid;
  logic [WAY_W-1:0] victim_way;
  logic             victim_ready = 1'b0;

  lru_replace_ctrl #(.SET_SIZE(SET_SIZE), .SET_COUNT(SET_COUNT)) dut (
    .clk(clk), .reset(reset),
    .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way),
    .miss_valid(miss_valid), .miss_set(miss_set), .miss_ready(miss_ready),
    .victim_valid(victim_valid), .victim_way(victim_way), .victim_ready(victim_ready)
  );

  initial forever #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: stamps, counter, and a request that waits SET_SIZE quiet scan cycles.
  logic [31:0] m_stamp [SET_COUNT][SET_SIZE];
  logic [31:0] m_cnt;
  int m_mode = 0;   // 0 idle, 1 searching, 2 offering
  int m_rem = 0;
  int m_set = 0;
  int m_vic = 0;
  bit m_started = 0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic int lru_of(input int s);
    int best = 0;
    for (int w = 1; w < SET_SIZE; w++)
      if (m_stamp[s][w] < m_stamp[s][best]) best = w;
    return best;
  endfunction

  task automatic model_step();
    int old_mode;
    if (reset) begin
      for (int s = 0; s < SET_COUNT; s++)
        for (int w = 0; w < SET_SIZE; w++) m_stamp[s][w] = '0;
      m_cnt = 32'd1; m_mode = 0; m_rem = 0; m_set = 0; m_vic = 0;
      return;
    end
    old_mode = m_mode;
    if (old_mode == 2 && victim_ready) begin
      m_stamp[m_set][m_vic] = m_cnt;
      m_cnt = sat_inc(m_cnt);
    end
    if (touch_valid) begin
      m_stamp[int'(touch_set)][int'(touch_way)] = m_cnt;
      m_cnt = sat_inc(m_cnt);
    end
    case (old_mode)
      0: if (miss_valid) begin m_mode = 1; m_set = int'(miss_set); m_rem = SET_SIZE; end
      1: begin
        if (touch_valid && int'(touch_set) == m_set) m_rem = SET_SIZE;
        else m_rem--;
        if (m_rem == 0) begin m_mode = 2; m_vic = lru_of(m_set); end
      end
      default: if (victim_ready) begin m_mode = 0; m_vic = 0; end
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
    m_started = 1;
  end

  initial forever begin
    @(negedge clk);
    if (m_started) begin
      chk("miss_ready", 32'(miss_ready), 32'(m_mode == 0));
      chk("victim_valid", 32'(victim_valid), 32'(m_mode == 2));
      chk("victim_way", 32'(victim_way), (m_mode == 2) ? 32'(m_vic) : 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1; touch_valid = 0; miss_valid = 0; victim_ready = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic touch(input int s, input int w);
    @(negedge clk);
    touch_valid = 1; touch_set = SET_W'(s); touch_way = WAY_W'(w);
    @(negedge clk);
    touch_valid = 0;
  endtask

  // Issue a miss; optionally touch (ts,tw) k cycles after the request cycle; return latency and victim.
  task automatic do_miss(input int s, input int tk, input int ts, input int tw,
                         output int lat, output int way);
    int c0;
    bit seen;
    @(negedge clk);
    miss_valid = 1; miss_set = SET_W'(s); c0 = cyc;
    seen = 0; lat = 0; way = 0;
    for (int k = 1; k < 40 && !seen; k++) begin
      @(negedge clk);
      miss_valid = 0;
      touch_valid = (k == tk); touch_set = SET_W'(ts); touch_way = WAY_W'(tw);
      if (victim_valid) begin
        seen = 1; lat = cyc - c0; way = int'(victim_way); touch_valid = 0;
      end
    end
    if (!seen) chk("victim_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_commit(input bit tv, input int ts, input int tw);
    victim_ready = 1; touch_valid = tv; touch_set = SET_W'(ts); touch_way = WAY_W'(tw);
    @(negedge clk);
    victim_ready = 0; touch_valid = 0;
  endtask

  int lat, way, nz;

  initial begin
    // Miss on a fresh set: way 0 after 5 cycles, commit stamps 1.
    do_reset();
    @(negedge clk);
    chk("rst_miss_ready", 32'(miss_ready), 32'd1);
    chk("rst_victim_valid", 32'(victim_valid), 32'd0);
    chk("rst_victim_way", 32'(victim_way), 32'd0);
    do_miss(3, -1, 0, 0, lat, way);
    chk("t1_latency", 32'(lat), 32'd5);
    chk("t1_victim", 32'(way), 32'd0);
    do_commit(0, 0, 0);
    chk("t1_stamp30", dut.stamp_q[3][0], 32'd1);
    chk("t1_counter", dut.counter_q, 32'd2);
    chk("t1_model_stamp", m_stamp[3][0], 32'd1);

    // Touched ways 0..2 leave way 3 as LRU, then way 0.
    do_reset();
    touch(2, 0); touch(2, 1); touch(2, 2);
    do_miss(2, -1, 0, 0, lat, way);
    chk("t2_victim_a", 32'(way), 32'd3);
    do_commit(0, 0, 0);
    chk("t2_stamp23", dut.stamp_q[2][3], 32'd4);
    do_miss(2, -1, 0, 0, lat, way);
    chk("t2_victim_b", 32'(way), 32'd0);
    chk("t2_latency", 32'(lat), 32'd5);
    do_commit(0, 0, 0);

    // Reverse-order touches; touch to another set during the scan does not restart it.
    do_reset();
    touch(5, 3); touch(5, 2); touch(5, 1); touch(5, 0);
    do_miss(5, 2, 6, 1, lat, way);
    chk("t3_victim", 32'(way), 32'd3);
    chk("t3_latency", 32'(lat), 32'd5);
    do_commit(0, 0, 0);
    chk("t3_stamp61", dut.stamp_q[6][1], 32'd5);

    // Same-set touch on the second scan cycle restarts the scan.
    do_reset();
    do_miss(1, 2, 1, 0, lat, way);
    chk("t4_victim", 32'(way), 32'd1);
    chk("t4_latency", 32'(lat), 32'd7);
    do_commit(0, 0, 0);

    // Commit and touch to the same entry on one edge at counter 7.
    do_reset();
    touch(0, 0); touch(0, 1); touch(0, 2); touch(0, 3); touch(7, 0); touch(7, 1);
    do_miss(4, -1, 0, 0, lat, way);
    chk("t5_victim", 32'(way), 32'd0);
    chk("t5_counter_pre", dut.counter_q, 32'd7);
    do_commit(1, 4, 0);
    chk("t5_stamp40", dut.stamp_q[4][0], 32'd8);
    chk("t5_counter", dut.counter_q, 32'd9);
    chk("t5_model_cnt", m_cnt, 32'd9);
    chk("t5_miss_ready", 32'(miss_ready), 32'd1);

    // Reset while offering, with every other input active, wins.
    do_reset();
    touch(2, 1);
    do_miss(2, -1, 0, 0, lat, way);
    chk("t6_victim_pre", 32'(way), 32'd0);
    reset = 1; victim_ready = 1; touch_valid = 1; touch_set = 3'd2; touch_way = 2'd0;
    miss_valid = 1; miss_set = 3'd5;
    @(negedge clk);
    reset = 0; victim_ready = 0; touch_valid = 0; miss_valid = 0;
    chk("t6_victim_valid", 32'(victim_valid), 32'd0);
    chk("t6_miss_ready", 32'(miss_ready), 32'd1);
    chk("t6_victim_way", 32'(victim_way), 32'd0);
    chk("t6_counter", dut.counter_q, 32'd1);
    nz = 0;
    for (int s = 0; s < SET_COUNT; s++)
      for (int w = 0; w < SET_SIZE; w++)
        if (dut.stamp_q[s][w] != 32'd0) nz++;
    chk("t6_nonzero_stamps", 32'(nz), 32'd0);
    do_miss(2, -1, 0, 0, lat, way);
    chk("t6_victim_post", 32'(way), 32'd0);
    do_commit(0, 0, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/lru_replace_ctrl.md
LRU_REPLACE_CTRL -- requirements
Module: lru_replace_ctrl

Interface
REQ-001 SHALL have parameter SET_SIZE, default CACHE_E, ways per set (power of two, >=2); WAY_W = $clog2(SET_SIZE).
REQ-002 SHALL have parameter SET_COUNT, default CACHE_S, number of sets (power of two, >=2); SET_W = $clog2(SET_COUNT).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port touch_valid, input, 1, a hit on (touch_set, touch_way) this cycle.
REQ-006 SHALL have port touch_set, input, SET_W, set index of the hit.
REQ-007 SHALL have port touch_way, input, WAY_W, way index of the hit.
REQ-008 SHALL have port miss_valid, input, 1, victim request for miss_set.
REQ-009 SHALL have port miss_set, input, SET_W, set index needing a victim.
REQ-010 SHALL have port miss_ready, output, 1, a request is accepted this cycle when miss_valid and miss_ready are both high.
REQ-011 SHALL have port victim_valid, output, 1, victim_way is valid and offered.
REQ-012 SHALL have port victim_way, output, WAY_W, chosen least-recently-used way.
REQ-013 SHALL have port victim_ready, input, 1, refill done; the victim is committed on the edge where victim_valid and victim_ready are both high.

Function
REQ-014 SHALL hold a 32-bit stamp per (set, way), reset to 0, where 0 means never used.
REQ-015 SHALL hold a 32-bit global counter; reset value 1; saturates at 0xFFFFFFFF and never wraps.
REQ-016 SHALL accept touches in every state with no backpressure: stamp[touch_set][touch_way] <= counter, then counter += 1.
REQ-017 SHALL implement FSM states IDLE, SEARCH and OFFER.
REQ-018 SHALL drive miss_ready = (state == IDLE) and victim_valid = (state == OFFER), both decoded from registered state.
REQ-019 IDLE: on acceptance, SHALL latch miss_set, set scan index 0, clear best candidate, and go to SEARCH.
REQ-020 SEARCH: SHALL examine one way per cycle in index order 0..SET_SIZE-1 and keep the minimum stamp.
REQ-021 SEARCH: on equal stamps, SHALL keep the lower way index.
REQ-022 SEARCH SHALL last exactly SET_SIZE cycles, then go to OFFER; victim_valid rises SET_SIZE+1 cycles after the accepting edge.
REQ-023 SEARCH restart: a touch to the latched set during SEARCH SHALL reset the scan to way 0 and the best candidate, extending latency.
REQ-024 OFFER: victim_way SHALL be held stable until the commit edge.
REQ-025 OFFER: a touch during OFFER SHALL update stamps and SHALL NOT change victim_way.
REQ-026 Commit SHALL set stamp[set][victim_way] <= counter, counter += 1, and go to IDLE, so miss_ready is high the next cycle.
REQ-027 Simultaneous commit and touch: commit SHALL take counter, touch SHALL take counter+1, and counter += 2 (saturating).
REQ-028 Simultaneous commit and touch to the same set and way: the touch value SHALL be stored.
REQ-029 victim_way SHALL be 0 whenever victim_valid is low.
REQ-030 A request cannot be accepted in the same cycle as a commit; miss_ready is low in OFFER.

Reset
REQ-031 reset high at an edge SHALL force state IDLE, all stamps 0, counter 1, and scan/candidate registers 0, in any state (including mid-SEARCH or mid-OFFER).
REQ-032 Reset SHALL take priority over simultaneous touch, miss, and victim_ready.
REQ-033 In the cycle after reset deasserts, SHALL drive miss_ready=1, victim_valid=0, victim_way=0.

Verification (SET_SIZE=4, SET_COUNT=8)
REQ-034 Reset, then miss set 3 accepted at edge N -> victim_valid high from cycle N+5 with victim_way=0; victim_ready -> stamp[3][0]=1, counter=2.
REQ-035 Touch set 2 ways 0,1,2 (stamps 1,2,3), then miss set 2 -> victim 3, commit stamp 4; a second miss on set 2 -> victim 0.
REQ-036 Touch set 5 ways 3,2,1,0 -> miss set 5 -> victim 3; touches to set 6 during SEARCH -> no restart, latency 5.
REQ-037 Miss set 1; touch set 1 way 0 on the 2nd SEARCH cycle -> scan restarts, victim 1, victim_valid delayed by 2 cycles versus no touch.
REQ-038 In OFFER with counter=7, victim_ready and a touch to the same way on the same edge -> stamp=8, counter=9, state IDLE.
REQ-039 Reset asserted during OFFER -> next cycle victim_valid=0, miss_ready=1, all stamps 0; a following miss -> victim 0.
